// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, reads or writes a word store,
// and presents the response LAT cycles after acceptance until the initiator takes it.
module mem_responder #(
  parameter int                ADDR_W = 32,
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
  parameter int                LAT    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_wen_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [3:0]        req_wmask_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int                IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              err_reg, err_next;
  logic              rd_sel_reg, rd_sel_next;
  logic [DATA_W-1:0] mem_rd_reg;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              addr_err;
  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        lane_we;

  assign req_ready_o = rst_i && (state_reg == IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign off         = req_addr_i - BASE;
  assign addr_err    = (req_addr_i[1:0] != 2'b00) || (off >= SPAN);
  assign idx         = off[IDX_W+1:2];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_we[gi] = accept && req_wen_i && !addr_err && req_wmask_i[gi];
  end

  // Store has no reset; the read port only loads on an accepted read and is
  // masked at the output so errors, writes and reset all present zero data.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (lane_we[b]) mem[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
    end
    if (accept && !req_wen_i) mem_rd_reg <= mem[idx];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      err_reg    <= 1'b0;
      rd_sel_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      err_reg    <= err_next;
      rd_sel_reg <= rd_sel_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    err_next    = err_reg;
    rd_sel_next = rd_sel_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          err_next    = addr_err;
          rd_sel_next = !req_wen_i && !addr_err;
          if (LAT == 1) begin
            state_next = RESP;
          end else begin
            state_next = BUSY;
            cnt_next   = 4'(LAT - 2);
          end
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd0) state_next = RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      RESP: begin
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_valid_o = (state_reg == RESP);
  assign rsp_err_o   = err_reg;
  assign rsp_rdata_o = rd_sel_reg ? mem_rd_reg : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: a LAT=2 instance and a LAT=1 instance checked
// against a word-array reference model driven by the address/mask rules.
module tb_mem_responder;

  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          DEPTH_A = 1024;
  localparam int          LAT_A   = 2;
  localparam int          DEPTH_B = 16;
  localparam int          LAT_B   = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_req_valid = 0, a_req_ready, a_req_wen = 0, a_rsp_valid, a_rsp_ready = 0, a_rsp_err;
  logic [31:0] a_req_addr = 0, a_req_wdata = 0, a_rsp_rdata;
  logic [3:0]  a_req_wmask = 0;
  logic        b_req_valid = 0, b_req_ready, b_req_wen = 0, b_rsp_valid, b_rsp_ready = 0, b_rsp_err;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0, b_rsp_rdata;
  logic [3:0]  b_req_wmask = 0;

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH_A), .BASE(BASE), .LAT(LAT_A)) u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_addr_i(a_req_addr),
    .req_wen_i(a_req_wen), .req_wdata_i(a_req_wdata), .req_wmask_i(a_req_wmask),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err)
  );

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH_B), .BASE(BASE), .LAT(LAT_B)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(b_req_addr),
    .req_wen_i(b_req_wen), .req_wdata_i(b_req_wdata), .req_wmask_i(b_req_wmask),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err)
  );

  int checks = 0;
  int fails  = 0;
  logic [31:0] model_a [DEPTH_A];
  logic [31:0] model_b [DEPTH_B];

  // Reference rules: aligned byte address inside [BASE, BASE+depth*4), with wrapping subtraction.
  function automatic logic addr_bad(input logic [31:0] a, input int depth);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) || (off >= 32'(depth * 4));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 2);
  endfunction

  task automatic model_a_apply(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                               input logic [3:0] wmask, output logic [31:0] rd, output logic er);
    er = addr_bad(addr, DEPTH_A);
    rd = '0;
    if (!er) begin
      if (wen) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask[b]) model_a[word_of(addr)][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        rd = model_a[word_of(addr)];
      end
    end
  endtask

  // Drives one transaction on instance A; called and returns at a falling edge.
  task automatic run_a(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                       input logic [3:0] wmask, input int hold, input logic early,
                       output int lat, output logic [31:0] rdata, output logic err,
                       output logic stable, output logic ready_after);
    int n;
    n = 0;
    lat = 99; rdata = 'x; err = 1'bx; stable = 1'b0; ready_after = 1'bx;
    a_req_addr = addr; a_req_wen = wen; a_req_wdata = wdata; a_req_wmask = wmask; a_req_valid = 1'b1;
    while (!a_req_ready && n < 20) begin @(negedge clk); n++; end
    if (!a_req_ready) begin a_req_valid = 1'b0; return; end
    @(negedge clk);
    a_req_valid = 1'b0;
    a_req_addr = $urandom; a_req_wen = 1'($urandom); a_req_wdata = $urandom; a_req_wmask = 4'($urandom);
    a_rsp_ready = early;
    n = 1;
    while (!a_rsp_valid && n < 40) begin @(negedge clk); n++; end
    a_rsp_ready = 1'b0;
    if (!a_rsp_valid) return;
    lat = n; rdata = a_rsp_rdata; err = a_rsp_err;
    stable = (a_req_ready === 1'b0);
    repeat (hold) begin
      @(negedge clk);
      if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== rdata || a_rsp_err !== err || a_req_ready !== 1'b0)
        stable = 1'b0;
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    ready_after = a_req_ready;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (a_rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b expected 0", a_rsp_valid); end
    checks++; if (a_rsp_err !== 1'b0) begin fails++; $display("FAIL rst_rsp_err: got %b expected 0", a_rsp_err); end
    checks++; if (a_rsp_rdata !== 32'h0) begin fails++; $display("FAIL rst_rsp_rdata: got %h expected 0", a_rsp_rdata); end
    checks++; if (a_req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready_low: got %b expected 0", a_req_ready); end
    checks++; if (b_req_ready !== 1'b0) begin fails++; $display("FAIL rst_b_req_ready_low: got %b expected 0", b_req_ready); end
    rst = 1'b1;
    #1;
    checks++; if (a_req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready_first: got %b expected 1", a_req_ready); end
    @(negedge clk);
  endtask

  task automatic test_fill();
    int lat; logic [31:0] rd, d; logic er, st, ra;
    for (int i = 0; i < DEPTH_A; i++) begin
      d = $urandom;
      model_a[i] = d;
      run_a(BASE + 32'(i * 4), 1'b1, d, 4'hF, 0, 1'b0, lat, rd, er, st, ra);
      checks++; if (er !== 1'b0 || lat != LAT_A) begin fails++; $display("FAIL fill_%0d: got err=%b lat=%0d expected err=0 lat=%0d", i, er, lat, LAT_A); end
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd, mrd; logic er, mer, st, ra;
    model_a_apply(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, mrd, mer);
    run_a(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (lat != 2) begin fails++; $display("FAIL wr_latency: got %0d expected 2", lat); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL wr_rsp: got err=%b data=%h expected err=0 data=0", er, rd); end
    checks++; if (ra !== 1'b1) begin fails++; $display("FAIL wr_ready_after: got %b expected 1", ra); end
    model_a_apply(32'h8000_0010, 1'b0, 32'h0, 4'h0, mrd, mer);
    run_a(32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (lat != 2) begin fails++; $display("FAIL rd_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin fails++; $display("FAIL rd_after_wr: got err=%b data=%h expected err=0 data=deadbeef", er, rd); end
  endtask

  task automatic test_partial_mask();
    int lat; logic [31:0] rd, mrd; logic er, mer, st, ra;
    model_a_apply(32'h8000_0010, 1'b1, 32'h1122_3344, 4'b0101, mrd, mer);
    run_a(32'h8000_0010, 1'b1, 32'h1122_3344, 4'b0101, 0, 1'b0, lat, rd, er, st, ra);
    run_a(32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (rd !== 32'hDE22_BE44 || er !== 1'b0) begin fails++; $display("FAIL partial_mask: got err=%b data=%h expected err=0 data=de22be44", er, rd); end
    model_a_apply(32'h8000_0010, 1'b1, 32'h5555_AAAA, 4'h0, mrd, mer);
    run_a(32'h8000_0010, 1'b1, 32'h5555_AAAA, 4'h0, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (er !== 1'b0) begin fails++; $display("FAIL mask0_err: got %b expected 0", er); end
    run_a(32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (rd !== 32'hDE22_BE44) begin fails++; $display("FAIL mask0_data: got %h expected de22be44", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd, mrd; logic er, mer, st, ra;
    run_a(32'h8000_0002, 1'b0, 32'h0, 4'h0, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL misaligned: got err=%b data=%h expected err=1 data=0", er, rd); end
    run_a(BASE + 32'(DEPTH_A * 4), 1'b0, 32'h0, 4'h0, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL past_end: got err=%b data=%h expected err=1 data=0", er, rd); end
    model_a_apply(32'h7FFF_FFFC, 1'b1, 32'hCAFE_F00D, 4'hF, mrd, mer);
    run_a(32'h7FFF_FFFC, 1'b1, 32'hCAFE_F00D, 4'hF, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (er !== 1'b1) begin fails++; $display("FAIL below_base: got err=%b expected 1", er); end
    run_a(BASE + 32'((DEPTH_A - 1) * 4), 1'b0, 32'h0, 4'h0, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (rd !== model_a[DEPTH_A-1]) begin fails++; $display("FAIL below_base_last_word: got %h expected %h", rd, model_a[DEPTH_A-1]); end
    run_a(BASE, 1'b0, 32'h0, 4'h0, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (rd !== model_a[0]) begin fails++; $display("FAIL below_base_word0: got %h expected %h", rd, model_a[0]); end
  endtask

  task automatic test_hold();
    int lat; logic [31:0] rd; logic er, st, ra;
    run_a(32'h8000_0010, 1'b0, 32'h0, 4'h0, 5, 1'b0, lat, rd, er, st, ra);
    checks++; if (st !== 1'b1) begin fails++; $display("FAIL hold_stable: got %b expected 1", st); end
    checks++; if (rd !== 32'hDE22_BE44 || er !== 1'b0) begin fails++; $display("FAIL hold_data: got err=%b data=%h expected err=0 data=de22be44", er, rd); end
    checks++; if (ra !== 1'b1) begin fails++; $display("FAIL hold_ready_after: got %b expected 1", ra); end
  endtask

  task automatic test_random();
    int lat, r, word, hold; logic [31:0] addr, wdata, rd, mrd; logic [3:0] wmask; logic wen, early, er, mer, st, ra;
    for (int i = 0; i < 120; i++) begin
      r     = $urandom_range(0, 9);
      word  = (r < 6) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH_A - 1);
      addr  = BASE + 32'(word * 4);
      if (r == 0)      addr[1:0] = 2'($urandom_range(1, 3));
      else if (r == 1) addr = BASE + 32'(DEPTH_A * 4) + 32'($urandom_range(0, 255) * 4);
      else if (r == 2) addr = BASE - 32'($urandom_range(1, 64) * 4);
      wen = 1'($urandom); wdata = $urandom; wmask = 4'($urandom);
      hold = $urandom_range(0, 3); early = 1'($urandom);
      model_a_apply(addr, wen, wdata, wmask, mrd, mer);
      run_a(addr, wen, wdata, wmask, hold, early, lat, rd, er, st, ra);
      checks++;
      if (rd !== mrd || er !== mer || lat != LAT_A || st !== 1'b1 || ra !== 1'b1) begin
        fails++;
        $display("FAIL rand_%0d addr=%h wen=%b: got data=%h err=%b lat=%0d stable=%b ready=%b expected data=%h err=%b lat=%0d stable=1 ready=1",
                 i, addr, wen, rd, er, lat, st, ra, mrd, mer, LAT_A);
      end
    end
  endtask

  task automatic test_lat1_back_to_back();
    logic [31:0] op_addr [32];
    logic [31:0] op_data [32];
    logic        op_wen  [32];
    logic [32:0] exp_q [$];
    logic [32:0] expv, gotv;
    int issued, got, cyc, last, w;
    logic pend;
    issued = 0; got = 0; cyc = 0; last = -1; pend = 1'b0;
    for (int i = 0; i < 32; i++) begin
      op_wen[i]  = (i < DEPTH_B);
      op_data[i] = $urandom;
      op_addr[i] = BASE + 32'(((i < DEPTH_B) ? i : $urandom_range(0, DEPTH_B - 1)) * 4);
    end
    op_addr[31] = BASE + 32'(DEPTH_B * 4);
    b_rsp_ready = 1'b1;
    b_req_addr = op_addr[0]; b_req_wen = op_wen[0]; b_req_wdata = op_data[0]; b_req_wmask = 4'hF; b_req_valid = 1'b1;
    while (got < 32 && cyc < 200) begin
      if (b_rsp_valid) begin
        gotv = {b_rsp_err, b_rsp_rdata};
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 33'bx;
        checks++; if (gotv !== expv) begin fails++; $display("FAIL lat1_rsp_%0d: got err/data=%h expected %h", got, gotv, expv); end
        if (last >= 0) begin
          checks++; if (cyc - last != 2) begin fails++; $display("FAIL lat1_spacing_%0d: got %0d cycles expected 2", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
      if (pend) begin
        pend = 1'b0;
        if (issued < 32) begin
          b_req_addr = op_addr[issued]; b_req_wen = op_wen[issued]; b_req_wdata = op_data[issued];
        end else begin
          b_req_valid = 1'b0;
        end
      end
      if (b_req_valid && b_req_ready) begin
        if (addr_bad(b_req_addr, DEPTH_B)) begin
          exp_q.push_back({1'b1, 32'h0});
        end else begin
          w = word_of(b_req_addr);
          if (b_req_wen) begin
            model_b[w] = b_req_wdata;
            exp_q.push_back({1'b0, 32'h0});
          end else begin
            exp_q.push_back({1'b0, model_b[w]});
          end
        end
        issued++;
        pend = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    b_rsp_ready = 1'b0; b_req_valid = 1'b0;
    checks++; if (got != 32) begin fails++; $display("FAIL lat1_count: got %0d responses expected 32", got); end
  endtask

  task automatic test_reset_mid();
    int lat, seen; logic [31:0] rd, d; logic er, st, ra;
    d = $urandom;
    seen = 0;
    a_req_addr = BASE + 32'h40; a_req_wen = 1'b1; a_req_wdata = d; a_req_wmask = 4'hF; a_req_valid = 1'b1;
    checks++; if (a_req_ready !== 1'b1) begin fails++; $display("FAIL mid_ready_before: got %b expected 1", a_req_ready); end
    @(negedge clk);
    a_req_valid = 1'b0;
    model_a[16] = d;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b0) begin fails++; $display("FAIL mid_in_reset: got valid=%b ready=%b expected valid=0 ready=0", a_rsp_valid, a_req_ready); end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (a_rsp_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin fails++; $display("FAIL mid_no_response: got %0d valid cycles expected 0", seen); end
    run_a(BASE + 32'h40, 1'b0, 32'h0, 4'h0, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (rd !== d || er !== 1'b0) begin fails++; $display("FAIL mid_write_kept: got err=%b data=%h expected err=0 data=%h", er, rd, d); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_partial_mask();
    test_errors();
    test_hold();
    test_random();
    test_lat1_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
